ram_cmd_arbiter: RTL
====================

RAM_CMD_ARBITER -- requirements
Module: ram_cmd_arbiter

Interface
REQ-001 Parameter: READ_LAT, default 1, number of cycles from the issue of the read-data command to the capture of ram_dout (legal 1..4).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req  input  2  per-requester transaction request; bit i = requester i.
REQ-005 we  input  2  per-requester direction; 1 = write, 0 = read.
REQ-006 addr0, addr1  input  8 each  requester RAM address.
REQ-007 wdata0, wdata1  input  8 each  requester write data.
REQ-008 ack  output  2  one-cycle completion pulse to the served requester.
REQ-009 rdata  output  8  read result; valid while the matching ack bit is high.
REQ-010 busy  output  1  high from grant until ack, inclusive.
REQ-011 ram_din  output  10  command word to RAM: [9:8] opcode, [7:0] payload.
REQ-012 ram_rx_valid  output  1  command strobe to RAM.
REQ-013 ram_dout  input  8  RAM read data, registered inside the RAM.

Function
REQ-014 The block SHALL be a single FSM with states IDLE, CMD1, CMD2, RWAIT, DONE.
REQ-015 All outputs SHALL be registered; there SHALL be no combinational path from req/we/addr/wdata to any output.
REQ-016 IDLE: when any req bit is high, the block SHALL grant one requester, latch its we/addr/wdata into internal registers, and enter CMD1 on the next edge.
REQ-017 Arbitration SHALL be round-robin via a 1-bit priority pointer: if both requesters are requesting, the one named by the pointer wins; otherwise the sole requester wins.
REQ-018 The pointer SHALL move to the non-served requester on entry to DONE.
REQ-019 CMD1: ram_rx_valid = 1; ram_din = {2'b00, addr} for a write, or {2'b10, addr} for a read; next state CMD2.
REQ-020 CMD2: ram_rx_valid = 1; ram_din = {2'b01, wdata} for a write (next state DONE), or {2'b11, 8'h00} for a read (next state RWAIT).
REQ-021 RWAIT: ram_rx_valid = 0; the block SHALL hold for READ_LAT cycles, then capture ram_dout into rdata and enter DONE.
REQ-022 DONE: ack[granted] = 1 for exactly one cycle, with rdata stable; next state IDLE.
REQ-023 Outside CMD1/CMD2, ram_rx_valid SHALL be 0 and ram_din SHALL hold its last value.
REQ-024 Latency from the edge sampling req in IDLE to ack high SHALL be 3 cycles for a write and 3+READ_LAT cycles for a read.
REQ-025 Once granted, a transaction SHALL complete even if req drops; the latched operands SHALL be used, not live inputs.
REQ-026 A requester still asserting req in the ack cycle SHALL be treated as a new request when the block returns to IDLE.
REQ-027 A write SHALL leave rdata unchanged.
REQ-028 ack SHALL never be two-hot, and ram_rx_valid SHALL never be high for more than 2 consecutive cycles per transaction.

Reset
REQ-029 When rst_n = 0 at a clock edge, the block SHALL go to IDLE and clear: pointer = 0, ack = 0, rdata = 8'h00, busy = 0, ram_rx_valid = 0, ram_din = 10'h000.
REQ-030 Reset mid-transaction SHALL abort it with no ack, and ram_rx_valid SHALL be 0 from the first reset cycle.
REQ-031 After rst_n rises, the first grant SHALL be possible on the next edge.

Verification
REQ-032 Single write: req=2'b01, we0=1, addr0=8'h3C, wdata0=8'hA5 -> ram_din 10'h03C then 10'h1A5 on consecutive cycles with ram_rx_valid high; ack=2'b01 three cycles after request sampling.
REQ-033 Read-back: after REQ-032, req=2'b01, we0=0, addr0=8'h3C -> ram_din 10'h23C then 10'h300; rdata=8'hA5 with ack=2'b01 at 3+READ_LAT cycles.
REQ-034 Contention: req=2'b11 held continuously after reset -> grants alternate 0,1,0,1; ack sequence 01,10,01,10.
REQ-035 Request drop: req0 deasserted during CMD2 -> transaction completes with the latched addr/wdata; ack0 still pulses once.
REQ-036 Reset during RWAIT: rst_n=0 for one cycle -> no ack, outputs at reset values, pointer=0; a subsequent req=2'b10 is served normally.
REQ-037 READ_LAT=3 build: the read of REQ-033 returns 8'hA5 with ack 6 cycles after request sampling.

Source files
------------

// File: rtl/ram_cmd_arbiter.sv
// ram_cmd_arbiter
//   Two-requester front end for a command-driven RAM. Chooses one requester
//   (round-robin when both ask), latches its operands, and sends a
//   two-word command sequence to the RAM over ram_din/ram_rx_valid:
//     write : {00,addr} then {01,wdata}
//     read  : {10,addr} then {11,8'h00}, then wait READ_LAT cycles and
//             capture ram_dout into rdata.
//   The transaction finishes with a one-cycle ack pulse to the requester
//   that was served.
//
// Ports
//   clk          : clock, everything updates on the rising edge
//   rst_n        : synchronous active-low reset
//   req[1:0]     : per-requester request
//   we[1:0]      : per-requester direction, 1 = write, 0 = read
//   addr0/addr1  : requester RAM addresses
//   wdata0/1     : requester write data
//   ack[1:0]     : one-cycle completion pulse to the served requester
//   rdata        : read result, valid while the matching ack bit is high
//   busy         : high from the grant cycle through the ack cycle
//   ram_din      : command word to the RAM, [9:8] opcode, [7:0] payload
//   ram_rx_valid : command strobe to the RAM
//   ram_dout     : registered read data from the RAM
//
// Parameter
//   READ_LAT     : cycles from the read-data command to the ram_dout
//                  capture, legal range 1..4

module ram_cmd_arbiter #(
  parameter int READ_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] we,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] ack,
  output logic [7:0] rdata,
  output logic       busy,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_dout
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD1  = 3'd1;
  localparam logic [2:0] ST_CMD2  = 3'd2;
  localparam logic [2:0] ST_RWAIT = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [1:0] OP_WADDR = 2'b00;
  localparam logic [1:0] OP_WDATA = 2'b01;
  localparam logic [1:0] OP_RADDR = 2'b10;
  localparam logic [1:0] OP_RDATA = 2'b11;

  // Last value of the RWAIT counter before the capture edge.
  localparam logic [1:0] LAT_LAST = 2'(READ_LAT - 1);

  logic [2:0] state,    state_nxt;
  logic       ptr,      ptr_nxt;
  logic       gnt,      gnt_nxt;
  logic       op_we,    op_we_nxt;
  logic [7:0] op_addr,  op_addr_nxt;
  logic [7:0] op_wdata, op_wdata_nxt;
  logic [1:0] wait_cnt, wait_cnt_nxt;

  logic [1:0] ack_nxt;
  logic [7:0] rdata_nxt;
  logic       busy_nxt;
  logic [9:0] ram_din_nxt;
  logic       ram_rx_valid_nxt;

  logic       pick;
  logic [1:0] ack_onehot;

  // Both requesting: the pointer decides. Otherwise the only requester wins,
  // which for 2'b01 / 2'b10 is simply req[1].
  assign pick       = (req == 2'b11) ? ptr : req[1];
  assign ack_onehot = gnt ? 2'b10 : 2'b01;

  // Every output is produced here as a next value and registered below, so
  // each output changes on the same edge that enters the state it belongs
  // to. Nothing in this block feeds an output port directly.
  always_comb begin
    state_nxt        = state;
    ptr_nxt          = ptr;
    gnt_nxt          = gnt;
    op_we_nxt        = op_we;
    op_addr_nxt      = op_addr;
    op_wdata_nxt     = op_wdata;
    wait_cnt_nxt     = wait_cnt;
    ack_nxt          = 2'b00;
    rdata_nxt        = rdata;
    busy_nxt         = busy;
    ram_din_nxt      = ram_din;
    ram_rx_valid_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        busy_nxt = 1'b0;
        if (req != 2'b00) begin
          gnt_nxt          = pick;
          op_we_nxt        = we[pick];
          op_addr_nxt      = pick ? addr1 : addr0;
          op_wdata_nxt     = pick ? wdata1 : wdata0;
          busy_nxt         = 1'b1;
          ram_rx_valid_nxt = 1'b1;
          ram_din_nxt      = {(we[pick] ? OP_WADDR : OP_RADDR),
                              (pick ? addr1 : addr0)};
          state_nxt        = ST_CMD1;
        end
      end

      ST_CMD1: begin
        ram_rx_valid_nxt = 1'b1;
        ram_din_nxt      = op_we ? {OP_WDATA, op_wdata} : {OP_RDATA, 8'h00};
        state_nxt        = ST_CMD2;
      end

      ST_CMD2: begin
        if (op_we) begin
          ack_nxt   = ack_onehot;
          ptr_nxt   = ~gnt;
          state_nxt = ST_DONE;
        end else begin
          wait_cnt_nxt = 2'd0;
          state_nxt    = ST_RWAIT;
        end
      end

      ST_RWAIT: begin
        if (wait_cnt == LAT_LAST) begin
          rdata_nxt = ram_dout;
          ack_nxt   = ack_onehot;
          ptr_nxt   = ~gnt;
          state_nxt = ST_DONE;
        end else begin
          wait_cnt_nxt = wait_cnt + 2'd1;
        end
      end

      ST_DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end

      default: begin
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset. Clearing the
  // outputs here is what aborts an in-flight transaction without an ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ptr          <= 1'b0;
      gnt          <= 1'b0;
      op_we        <= 1'b0;
      op_addr      <= 8'h00;
      op_wdata     <= 8'h00;
      wait_cnt     <= 2'd0;
      ack          <= 2'b00;
      rdata        <= 8'h00;
      busy         <= 1'b0;
      ram_din      <= 10'h000;
      ram_rx_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      gnt          <= gnt_nxt;
      op_we        <= op_we_nxt;
      op_addr      <= op_addr_nxt;
      op_wdata     <= op_wdata_nxt;
      wait_cnt     <= wait_cnt_nxt;
      ack          <= ack_nxt;
      rdata        <= rdata_nxt;
      busy         <= busy_nxt;
      ram_din      <= ram_din_nxt;
      ram_rx_valid <= ram_rx_valid_nxt;
    end
  end

  // Structural guarantees of the command/ack protocol.
  a_ack_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(ack));

  a_valid_max2 : assert property (@(posedge clk) disable iff (!rst_n)
    (ram_rx_valid && $past(ram_rx_valid)) |=> !ram_rx_valid);

endmodule
